alu_div_seq: RTL

//  Multi-cycle 32-bit integer divider that sequences the shared 32-bit ALU instead of owning a subtractor.

---
 rtl/alu_div_seq_pkg.sv | 33 +++
 rtl/alu_div_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_div_seq_pkg.sv
// Shared definitions for the ALU-sequencing divider: ALU control codes and
// divider FSM state encodings. The signed states exist only when
// ALU_DIV_SIGNED_EN is defined.
package alu_div_seq_pkg;

    localparam logic [2:0] ALU_ADDU = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_SUBU = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMP   = 3'd1,
        ST_SUB   = 3'd2,
        ST_DONE  = 3'd3
`ifdef ALU_DIV_SIGNED_EN
        ,
        ST_NEG_A = 3'd4,
        ST_NEG_B = 3'd5,
        ST_FIX_Q = 3'd6,
        ST_FIX_R = 3'd7
`endif
    } div_state_e;

    // Partial remainder shifted left by one with the next dividend bit brought in.
    function automatic logic [31:0] shift_in(input logic [31:0] rem, input logic [31:0] dq);
        return {rem[30:0], dq[31]};
    endfunction

endpackage

// File: rtl/alu_div_seq.sv
// alu_div_seq: multi-cycle 32-bit restoring divider that borrows the shared
// execute-stage ALU (sltu compare, then subu) instead of owning a subtractor.
// One quotient bit every two cycles; divide-by-zero resolves in one cycle.
// Optional feature macro: ALU_DIV_SIGNED_EN (signed divide via signed_op,
// adding NEG_A/NEG_B/FIX_Q/FIX_R steps for a fixed 69-cycle latency).
module alu_div_seq
    import alu_div_seq_pkg::*;
#(
    parameter logic [31:0] ZERO_Q = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero,
    output logic [31:0] alu_x,
    output logic [31:0] alu_y,
    output logic [2:0]  alu_ctr,
    input  logic [31:0] alu_r
);

    div_state_e  state_r;
    div_state_e  state_next_s;

    logic [31:0] rem_r;
    logic [31:0] dq_r;
    logic [31:0] dsr_r;
    logic [4:0]  cnt_r;
    logic        qb_r;
    logic        zero_r;
    logic        busy_r;
    logic        done_r;
    logic [31:0] quotient_r;
    logic [31:0] remainder_r;
    logic        dbz_r;

    logic        accept_s;
    logic [31:0] rs_s;

`ifdef ALU_DIV_SIGNED_EN
    logic        sgn_r;
    logic        neg_a_r;
    logic        neg_b_r;
`else
    logic        signed_op_unused_s;
    assign signed_op_unused_s = signed_op;
`endif

    assign accept_s    = start & ~busy_r & (state_r == ST_IDLE);
    assign rs_s        = shift_in(rem_r, dq_r);

    assign busy        = busy_r;
    assign done        = done_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_r;

    // State register; reset aborts any divide in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state sequencing and the operands/opcode presented to the shared ALU.
    always_comb begin
        state_next_s = state_r;
        alu_x        = 32'd0;
        alu_y        = 32'd0;
        alu_ctr      = ALU_ADDU;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (divisor == 32'd0) begin
                        state_next_s = ST_DONE;
                    end else begin
`ifdef ALU_DIV_SIGNED_EN
                        if (signed_op) begin
                            state_next_s = ST_NEG_A;
                        end else begin
                            state_next_s = ST_CMP;
                        end
`else
                        state_next_s = ST_CMP;
`endif
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CMP: begin
                alu_x        = rs_s;
                alu_y        = dsr_r;
                alu_ctr      = ALU_SLTU;
                state_next_s = ST_SUB;
            end
            ST_SUB: begin
                alu_x   = rs_s;
                alu_y   = dsr_r;
                alu_ctr = ALU_SUBU;
                if (cnt_r == 5'd0) begin
`ifdef ALU_DIV_SIGNED_EN
                    if (sgn_r) begin
                        state_next_s = ST_FIX_Q;
                    end else begin
                        state_next_s = ST_DONE;
                    end
`else
                    state_next_s = ST_DONE;
`endif
                end else begin
                    state_next_s = ST_CMP;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
`ifdef ALU_DIV_SIGNED_EN
            ST_NEG_A: begin
                alu_y        = dq_r;
                alu_ctr      = ALU_SUBU;
                state_next_s = ST_NEG_B;
            end
            ST_NEG_B: begin
                alu_y        = dsr_r;
                alu_ctr      = ALU_SUBU;
                state_next_s = ST_CMP;
            end
            ST_FIX_Q: begin
                alu_y        = dq_r;
                alu_ctr      = ALU_SUBU;
                state_next_s = ST_FIX_R;
            end
            ST_FIX_R: begin
                alu_y        = rem_r;
                alu_ctr      = ALU_SUBU;
                state_next_s = ST_DONE;
            end
`endif
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, one quotient bit per CMP/SUB pair, result publication.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_r       <= 32'd0;
            dq_r        <= 32'd0;
            dsr_r       <= 32'd0;
            cnt_r       <= 5'd0;
            qb_r        <= 1'b0;
            zero_r      <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            quotient_r  <= 32'd0;
            remainder_r <= 32'd0;
            dbz_r       <= 1'b0;
`ifdef ALU_DIV_SIGNED_EN
            sgn_r       <= 1'b0;
            neg_a_r     <= 1'b0;
            neg_b_r     <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        busy_r <= 1'b1;
                        dbz_r  <= 1'b0;
                        dsr_r  <= divisor;
                        cnt_r  <= 5'd31;
                        zero_r <= (divisor == 32'd0);
`ifdef ALU_DIV_SIGNED_EN
                        sgn_r   <= signed_op;
                        neg_a_r <= signed_op & dividend[31];
                        neg_b_r <= signed_op & divisor[31];
`endif
                        // Divide-by-zero pre-loads its result so DONE simply publishes it.
                        if (divisor == 32'd0) begin
                            dq_r  <= ZERO_Q;
                            rem_r <= dividend;
                        end else begin
                            dq_r  <= dividend;
                            rem_r <= 32'd0;
                        end
                    end
                end
                ST_CMP: begin
                    // A set bit 31 before the shift means the 33-bit remainder already exceeds the divisor.
                    qb_r <= rem_r[31] | ~alu_r[0];
                end
                ST_SUB: begin
                    rem_r <= qb_r ? alu_r : rs_s;
                    dq_r  <= {dq_r[30:0], qb_r};
                    cnt_r <= cnt_r - 5'd1;
                end
                ST_DONE: begin
                    quotient_r  <= dq_r;
                    remainder_r <= rem_r;
                    done_r      <= 1'b1;
                    busy_r      <= 1'b0;
                    dbz_r       <= zero_r;
                end
`ifdef ALU_DIV_SIGNED_EN
                ST_NEG_A: begin
                    if (neg_a_r) begin
                        dq_r <= alu_r;
                    end
                end
                ST_NEG_B: begin
                    if (neg_b_r) begin
                        dsr_r <= alu_r;
                    end
                end
                ST_FIX_Q: begin
                    if (neg_a_r ^ neg_b_r) begin
                        dq_r <= alu_r;
                    end
                end
                ST_FIX_R: begin
                    if (neg_a_r) begin
                        rem_r <= alu_r;
                    end
                end
`endif
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
